// File: rtl/maq_ms.sv
// Minutes/seconds time-keeping FSM with RUN / SET_HOUR / SET_MIN modes.
// Drives BCD digits and a registered hour-advance request for the hour counter.
module maq_ms (
    input  logic       maq_ms_clock,
    input  logic       maq_ms_reset,
    input  logic       maq_ms_enable1hz,
    input  logic       maq_ms_botao_modo,
    input  logic       maq_ms_botao_incremento,
    output logic [3:0] maq_ms_bcd_s_lsd,
    output logic [2:0] maq_ms_bcd_s_msd,
    output logic [3:0] maq_ms_bcd_m_lsd,
    output logic [2:0] maq_ms_bcd_m_msd,
    output logic       maq_ms_incremento_hora,
    output logic [1:0] maq_ms_modo
);

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] s_lsd_q, s_lsd_d;
    logic [2:0] s_msd_q, s_msd_d;
    logic [3:0] m_lsd_q, m_lsd_d;
    logic [2:0] m_msd_q, m_msd_d;
    logic       pending_q, pending_d;

    logic sec_inc, sec_clr, min_inc, pending_set;
    logic sec_at_59, min_at_59;

    assign sec_at_59 = (s_msd_q == 3'd5) && (s_lsd_q == 4'd9);
    assign min_at_59 = (m_msd_q == 3'd5) && (m_lsd_q == 4'd9);

    always_comb begin
        state_d     = state_q;
        s_lsd_d     = s_lsd_q;
        s_msd_d     = s_msd_q;
        m_lsd_d     = m_lsd_q;
        m_msd_d     = m_msd_q;
        pending_d   = pending_q;
        sec_inc     = 1'b0;
        sec_clr     = 1'b0;
        min_inc     = 1'b0;
        pending_set = 1'b0;

        // Counting/adjustment decisions use the current state; a mode press wins over increment.
        case (state_q)
            RUN: begin
                if (maq_ms_botao_modo) begin
                    state_d = SET_HOUR;
                end
                if (maq_ms_enable1hz) begin
                    sec_inc = 1'b1;
                    min_inc = sec_at_59;
                end
            end
            SET_HOUR: begin
                if (maq_ms_botao_modo) begin
                    state_d = SET_MIN;
                end else if (maq_ms_botao_incremento && !pending_q) begin
                    pending_set = 1'b1;
                end
            end
            SET_MIN: begin
                if (maq_ms_botao_modo) begin
                    state_d = RUN;
                    sec_clr = 1'b1;
                end else if (maq_ms_botao_incremento) begin
                    min_inc = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (sec_clr) begin
            s_lsd_d = '0;
            s_msd_d = '0;
        end else if (sec_inc) begin
            if (s_lsd_q == 4'd9) begin
                s_lsd_d = '0;
                s_msd_d = (s_msd_q == 3'd5) ? 3'd0 : s_msd_q + 3'd1;
            end else begin
                s_lsd_d = s_lsd_q + 4'd1;
            end
        end

        if (min_inc) begin
            if (m_lsd_q == 4'd9) begin
                m_lsd_d = '0;
                m_msd_d = (m_msd_q == 3'd5) ? 3'd0 : m_msd_q + 3'd1;
            end else begin
                m_lsd_d = m_lsd_q + 4'd1;
            end
        end

        // A request is consumed by the tick after it was latched, in any mode.
        if (maq_ms_enable1hz && pending_q) begin
            pending_d = 1'b0;
        end else if (pending_set) begin
            pending_d = 1'b1;
        end
    end

    always_ff @(posedge maq_ms_clock) begin
        if (maq_ms_reset) begin
            state_q   <= RUN;
            s_lsd_q   <= '0;
            s_msd_q   <= '0;
            m_lsd_q   <= '0;
            m_msd_q   <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            s_lsd_q   <= s_lsd_d;
            s_msd_q   <= s_msd_d;
            m_lsd_q   <= m_lsd_d;
            m_msd_q   <= m_msd_d;
            pending_q <= pending_d;
        end
    end

    assign maq_ms_bcd_s_lsd       = s_lsd_q;
    assign maq_ms_bcd_s_msd       = s_msd_q;
    assign maq_ms_bcd_m_lsd       = m_lsd_q;
    assign maq_ms_bcd_m_msd       = m_msd_q;
    assign maq_ms_modo            = state_q;
    assign maq_ms_incremento_hora = pending_q | ((state_q == RUN) && min_at_59 && sec_at_59);

endmodule
